// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, flag bit positions and
// the arithmetic-op classifier used by the carry register.
// No logic of its own; imported by alu_core and alu_pipe.
package alu_pkg;

  localparam logic [3:0] OP_INCA   = 4'h0;
  localparam logic [3:0] OP_DECA   = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_ABS    = 4'h4;
  localparam logic [3:0] OP_NEGA   = 4'h5;
  localparam logic [3:0] OP_ADDC   = 4'h6;
  localparam logic [3:0] OP_NEGB   = 4'h7;
  localparam logic [3:0] OP_AND    = 4'h8;
  localparam logic [3:0] OP_OR     = 4'h9;
  localparam logic [3:0] OP_XOR    = 4'hA;
  localparam logic [3:0] OP_INVB   = 4'hB;
  localparam logic [3:0] OP_PASSA  = 4'hC;
  localparam logic [3:0] OP_INVA   = 4'hD;
  localparam logic [3:0] OP_ZEROES = 4'hE;
  localparam logic [3:0] OP_ONES   = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Codes 0-7 go through the adder and update the chained carry.
  function automatic logic is_arith(input logic [3:0] op);
    return !op[3];
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// slave: the ALU (consumes in_*, out_ready, sticky_clr; drives the rest).
// master: the operand muxes / writeback side.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       inst;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic [3:0]       flags;
  logic             sticky_clr;
  logic             sticky_v;

  modport master (
    output in_valid, a, b, inst, out_ready, sticky_clr,
    input  in_ready, out_valid, z, flags, sticky_v
  );

  modport slave (
    input  in_valid, a, b, inst, out_ready, sticky_clr,
    output in_ready, out_valid, z, flags, sticky_v
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: 16 opcodes, {N,Z,C,V} flags, optional signed saturation.
// Latency 0 (pure combinational); no handshake, backpressure handled by the caller.
// Ports: a, b, inst, carry_in (for ADDC) -> z, flags {N,Z,C,V}.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit SAT   = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       inst,
  input  logic             carry_in,
  output logic [WIDTH-1:0] z,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  // Every arithmetic op is expressed as x + y + cin on a WIDTH+1 adder so that
  // carry and overflow come out of one place.
  logic [WIDTH-1:0] x, y, lres, raw;
  logic             cin, arith, c, v;
  logic [WIDTH:0]   sum;

  always_comb begin
    x     = '0;
    y     = '0;
    cin   = 1'b0;
    arith = 1'b1;
    lres  = '0;
    case (inst)
      OP_INCA:   begin x = a; y = {{(WIDTH-1){1'b0}}, 1'b1}; end
      OP_DECA:   begin x = a; y = ~{{(WIDTH-1){1'b0}}, 1'b1}; cin = 1'b1; end
      OP_ADD:    begin x = a; y = b; end
      OP_SUB:    begin x = a; y = ~b; cin = 1'b1; end
      OP_ABS: begin
        // Negative A behaves as NEGA; non-negative A is a plain pass-through.
        if (a[MSB]) begin
          y   = ~a;
          cin = 1'b1;
        end else begin
          arith = 1'b0;
          lres  = a;
        end
      end
      OP_NEGA:   begin y = ~a; cin = 1'b1; end
      OP_ADDC:   begin x = a; y = b; cin = carry_in; end
      OP_NEGB:   begin y = ~b; cin = 1'b1; end
      OP_AND:    begin arith = 1'b0; lres = a & b; end
      OP_OR:     begin arith = 1'b0; lres = a | b; end
      OP_XOR:    begin arith = 1'b0; lres = a ^ b; end
      OP_INVB:   begin arith = 1'b0; lres = ~b; end
      OP_PASSA:  begin arith = 1'b0; lres = a; end
      OP_INVA:   begin arith = 1'b0; lres = ~a; end
      OP_ZEROES: begin arith = 1'b0; lres = '0; end
      default:   begin arith = 1'b0; lres = '1; end
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  assign c   = arith & sum[WIDTH];
  // Same-signed adder inputs producing a differently-signed result. Negating
  // the most-negative value lands here too (0 + 0111..1 + 1 = 1000..0).
  assign v   = arith & (x[MSB] == y[MSB]) & (sum[MSB] != x[MSB]);
  assign raw = arith ? sum[WIDTH-1:0] : lres;

  always_comb begin
    z = raw;
    // Overflow direction follows the sign of the (shared) adder inputs.
    if (SAT && v)
      z = x[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // N and Z reflect the saturated result.
  assign flags = {z[MSB], (z == '0), c, v};

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with carry chaining and sticky overflow.
// Latency: op registered into stage 1 on accept, result registered into stage 2 on the next edge.
// Backpressure: out_ready stalls stage 2, which ripples combinationally to in_ready; results hold stable.
// Ports: clk, rst (async active-high), io (alu_pipe_if.slave).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit SAT   = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  alu_pipe_if.slave io
);

  logic             v1, v2, ready2;
  logic [WIDTH-1:0] a1, b1, z2, core_z;
  logic [3:0]       op1, f2, core_f;
  logic             carry_q, sticky_q;

  assign ready2      = !v2 || io.out_ready;
  assign io.in_ready = !v1 || ready2;

  alu_core #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_core (
    .a        (a1),
    .b        (b1),
    .inst     (op1),
    .carry_in (carry_q),
    .z        (core_z),
    .flags    (core_f)
  );

  // Stage 1: operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      op1 <= '0;
    end else if (io.in_ready) begin
      v1 <= io.in_valid;
      if (io.in_valid) begin
        a1  <= io.a;
        b1  <= io.b;
        op1 <= io.inst;
      end
    end
  end

  // Stage 2: compute and register. carry_q is only touched here, on the same
  // edge the op advances, so a back-to-back ADDC sees its predecessor's carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2      <= 1'b0;
      z2      <= '0;
      f2      <= '0;
      carry_q <= 1'b0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        z2 <= core_z;
        f2 <= core_f;
        if (is_arith(op1))
          carry_q <= core_f[FLAG_C];
      end
    end
  end

  // Set on consumption of a V result; set beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sticky_q <= 1'b0;
    else if (io.out_valid && io.out_ready && f2[FLAG_V])
      sticky_q <= 1'b1;
    else if (io.sticky_clr)
      sticky_q <= 1'b0;
  end

  assign io.out_valid = v2;
  assign io.z         = z2;
  assign io.flags     = f2;
  assign io.sticky_v  = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a 32-bit non-saturating and a 16-bit saturating instance.
// Expected results come from an integer reference model at accept time and are
// compared in order whenever a result is presented.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(32)) ia ();
  alu_pipe_if #(.WIDTH(16)) ib ();

  alu_pipe #(.WIDTH(32), .SAT(1'b0)) dut32 (.clk(clk), .rst(rst), .io(ia));
  alu_pipe #(.WIDTH(16), .SAT(1'b1)) dut16 (.clk(clk), .rst(rst), .io(ib));

  int total = 0;
  int bad   = 0;
  logic [35:0] q32[$];
  logic [19:0] q16[$];
  bit c32 = 1'b0;
  bit c16 = 1'b0;
  bit rr_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input int w, input longint unsigned v);
    longint one = 1;
    if (v[w-1]) return longint'(v) - (one << w);
    return longint'(v);
  endfunction

  // Reference: unsigned sum for carry, exact signed sum for overflow.
  function automatic void model(input int w, input bit sat, input logic [3:0] op,
                                input longint unsigned a, input longint unsigned b,
                                input bit cin, output longint unsigned z, output logic [3:0] fl);
    longint unsigned one = 1;
    longint unsigned mask, u;
    longint s, smax, smin;
    bit ar;
    mask = (one << w) - one;
    smax = longint'((one << (w - 1)) - one);
    smin = -longint'(one << (w - 1));
    u = 0; s = 0; ar = 1'b1; z = 0; fl = 4'b0;
    case (op)
      4'h0: begin u = a + one; s = sx(w, a) + 1; end
      4'h1: begin u = a + (mask - one) + one; s = sx(w, a) - 1; end
      4'h2: begin u = a + b; s = sx(w, a) + sx(w, b); end
      4'h3: begin u = a + (mask ^ b) + one; s = sx(w, a) - sx(w, b); end
      4'h4: begin
        if (a[w-1]) begin u = (mask ^ a) + one; s = -sx(w, a); end
        else begin ar = 1'b0; z = a; end
      end
      4'h5: begin u = (mask ^ a) + one; s = -sx(w, a); end
      4'h6: begin u = a + b + longint'(cin); s = sx(w, a) + sx(w, b) + longint'(cin); end
      4'h7: begin u = (mask ^ b) + one; s = -sx(w, b); end
      4'h8: begin ar = 1'b0; z = a & b; end
      4'h9: begin ar = 1'b0; z = a | b; end
      4'hA: begin ar = 1'b0; z = a ^ b; end
      4'hB: begin ar = 1'b0; z = mask ^ b; end
      4'hC: begin ar = 1'b0; z = a; end
      4'hD: begin ar = 1'b0; z = mask ^ a; end
      4'hE: begin ar = 1'b0; z = 0; end
      default: begin ar = 1'b0; z = mask; end
    endcase
    if (ar) begin
      z = u & mask;
      fl[1] = u[w];
      fl[0] = (s > smax) || (s < smin);
      if (sat && fl[0])
        z = (s > smax) ? longint'(smax) : (longint'(smin) & mask);
    end
    fl[3] = z[w-1];
    fl[2] = (z == 0);
  endfunction

  task automatic send32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    longint unsigned zz;
    logic [3:0] f;
    ia.in_valid = 1'b1; ia.inst = op; ia.a = a; ia.b = b;
    do begin @(negedge clk); n++; end while (!ia.in_ready && n < 100);
    if (ia.in_ready) begin
      model(32, 1'b0, op, a, b, c32, zz, f);
      if (!op[3]) c32 = f[1];
      q32.push_back({zz[31:0], f});
    end else check("accept32", ia.in_ready, 1);
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
  endtask

  task automatic send16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    longint unsigned zz;
    logic [3:0] f;
    ib.in_valid = 1'b1; ib.inst = op; ib.a = a; ib.b = b;
    do begin @(negedge clk); n++; end while (!ib.in_ready && n < 100);
    if (ib.in_ready) begin
      model(16, 1'b1, op, a, b, c16, zz, f);
      if (!op[3]) c16 = f[1];
      q16.push_back({zz[15:0], f});
    end else check("accept16", ib.in_ready, 1);
    @(posedge clk); #1;
    ib.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0 || ia.out_valid || ib.out_valid) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("drain", (n < 500), 1);
  endtask

  // Compare whenever a result is presented (also while stalled, so a held
  // result must keep matching the head); pop only on consumption.
  always @(negedge clk) begin
    if (!rst && ia.out_valid) begin
      if (q32.size() == 0) check("out32_unexpected", ia.out_valid, 0);
      else begin
        check("z32", ia.z, q32[0][35:4]);
        check("flags32", ia.flags, q32[0][3:0]);
        if (ia.out_ready) void'(q32.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ib.out_valid) begin
      if (q16.size() == 0) check("out16_unexpected", ib.out_valid, 0);
      else begin
        check("z16", ib.z, q16[0][19:4]);
        check("flags16", ib.flags, q16[0][3:0]);
        if (ib.out_ready) void'(q16.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_en) ia.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] op;
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.a = '0; ia.b = '0; ia.inst = '0; ia.out_ready = 1'b1; ia.sticky_clr = 1'b0;
    ib.in_valid = 1'b0; ib.a = '0; ib.b = '0; ib.inst = '0; ib.out_ready = 1'b1; ib.sticky_clr = 1'b0;
    #2;
    check("rst_out_valid", ia.out_valid, 0);
    check("rst_z", ia.z, 0);
    check("rst_flags", ia.flags, 0);
    check("rst_sticky", ia.sticky_v, 0);
    check("rst_out_valid16", ib.out_valid, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_idle", ia.in_ready, 1);

    // Latency: registered into stage 1 on accept, presented after the next edge.
    ia.out_ready = 1'b0;
    send32(OP_PASSA, 32'h1234_5678, 32'h0);
    check("latency_s1", ia.out_valid, 0);
    @(posedge clk); #1;
    check("latency_s2", ia.out_valid, 1);
    ia.out_ready = 1'b1;
    drain();

    // Wrap-around add then carry-chained add, back to back.
    send32(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    send32(OP_ADDC, 32'h0, 32'h0);
    drain();
    check("sticky_idle", ia.sticky_v, 0);

    // Signed overflow on subtract and sticky behaviour.
    send32(OP_SUB, 32'h8000_0000, 32'h1);
    drain();
    check("sticky_set", ia.sticky_v, 1);
    ia.out_ready = 1'b0;
    send32(OP_INCA, 32'h7FFF_FFFF, 32'h0);
    begin
      int n = 0;
      while (!ia.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("stall_valid", ia.out_valid, 1);
    end
    ia.out_ready = 1'b1;
    ia.sticky_clr = 1'b1;
    @(posedge clk); #1;
    ia.sticky_clr = 1'b0;
    check("sticky_set_wins", ia.sticky_v, 1);
    ia.sticky_clr = 1'b1;
    @(posedge clk); #1;
    ia.sticky_clr = 1'b0;
    check("sticky_clr", ia.sticky_v, 0);

    // Saturating 16-bit instance.
    send16(OP_ADD, 16'h7FFF, 16'h0001);
    send16(OP_ABS, 16'h8000, 16'h0);
    send16(OP_DECA, 16'h0, 16'h0);
    send16(OP_SUB, 16'h8000, 16'h0001);
    send16(OP_NEGB, 16'h0, 16'h8000);
    send16(OP_ABS, 16'h0005, 16'h0);
    send16(OP_XOR, 16'hA5A5, 16'hFFFF);
    drain();

    // Full pipeline under backpressure: in_ready drops after two accepts.
    ia.out_ready = 1'b0;
    send32(OP_XOR, 32'hDEAD_BEEF, 32'hFFFF_0000);
    send32(OP_OR, 32'h0000_00F0, 32'h0F00_0000);
    @(negedge clk);
    check("in_ready_full", ia.in_ready, 0);
    check("out_valid_full", ia.out_valid, 1);
    @(posedge clk); #1;
    ia.out_ready = 1'b1;
    drain();

    // Back-to-back random ops with random downstream readiness.
    rr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = (i == 3) ? OP_ADDC : 4'($urandom_range(0, 15));
      send32(op, $urandom, $urandom);
    end
    rr_en = 1'b0;
    ia.out_ready = 1'b1;
    drain();

    // Asynchronous reset mid-stream with carry_q = 1 and results in flight.
    ia.out_ready = 1'b0;
    send32(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    send32(OP_AND, 32'h0000_00F0, 32'h0000_00FF);
    @(posedge clk); #3;
    check("pre_rst_valid", ia.out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", ia.out_valid, 0);
    q32.delete();
    q16.delete();
    c32 = 1'b0;
    c16 = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    ia.out_ready = 1'b1;
    @(posedge clk); #1;
    send32(OP_ADDC, 32'h0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
